// File: rtl/tx_msg_seq.sv
// tx_msg_seq: debounced button press streams "HELLO TANG" to a UART TX byte port; TX_MSG_CRLF_EN appends CR/LF
module tx_msg_seq #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W = 8
) (
   input  logic             SYS_CLK,
   input  logic             SYS_RST,
   input  logic             BTN,
   output logic [7:0]       TX_DATA,
   output logic             TX_VALID,
   input  logic             TX_READY,
   output logic             BUSY,
   output logic [CNT_W-1:0] MSG_COUNT
);
`ifdef TX_MSG_CRLF_EN
   typedef enum logic [1:0] {IDLE, SEND, CR, LF} state_t;
`else
   typedef enum logic {IDLE, SEND} state_t;
`endif
   localparam logic [7:0] MSG [10] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h54, 8'h41, 8'h4E, 8'h47};
   localparam logic [15:0] DCNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
   logic [1:0]       sync_q;
   logic             deb_q, deb_prev_q;
   logic [15:0]      dcnt_q;
   state_t           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s, trig, hs;
   assign s = sync_q[1];
   assign trig = deb_q & ~deb_prev_q;
   assign hs = valid_q & TX_READY;
   assign TX_DATA = data_q;
   assign TX_VALID = valid_q;
   assign BUSY = busy_q;
   assign MSG_COUNT = cnt_q;
   // synchronise the raw button and only follow a level that persists DEBOUNCE_CYCLES cycles
   always_ff @(posedge SYS_CLK) begin
      if (SYS_RST) begin
         sync_q <= '0;
         deb_q <= 1'b0;
         deb_prev_q <= 1'b0;
         dcnt_q <= '0;
      end else begin
         sync_q <= {sync_q[0], BTN};
         deb_prev_q <= deb_q;
         if (s == deb_q) dcnt_q <= '0;
         else if (dcnt_q == DCNT_LAST) begin
            deb_q <= s;
            dcnt_q <= '0;
         end else dcnt_q <= dcnt_q + 16'd1;
      end
   end
   // message sequencer state and registered outputs
   always_ff @(posedge SYS_CLK) begin
      if (SYS_RST) begin
         state_q <= IDLE;
         idx_q <= '0;
         data_q <= '0;
         valid_q <= 1'b0;
         busy_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         data_q <= data_d;
         valid_q <= valid_d;
         busy_q <= busy_d;
         cnt_q <= cnt_d;
      end
   end
   // next byte on each handshake; presses during a message are simply not looked at
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      data_d = data_q;
      valid_d = valid_q;
      busy_d = busy_q;
      cnt_d = cnt_q;
      case (state_q)
         IDLE: if (trig) begin
            state_d = SEND;
            idx_d = '0;
            data_d = MSG[0];
            valid_d = 1'b1;
            busy_d = 1'b1;
         end
         SEND: if (hs) begin
            if (idx_q != 4'd9) begin
               idx_d = idx_q + 4'd1;
               data_d = MSG[idx_d];
            end else begin
`ifdef TX_MSG_CRLF_EN
               state_d = CR;
               data_d = 8'h0D;
`else
               state_d = IDLE;
               valid_d = 1'b0;
               busy_d = 1'b0;
               cnt_d = cnt_q + CNT_W'(1);
`endif
            end
         end
`ifdef TX_MSG_CRLF_EN
         CR: if (hs) begin
            state_d = LF;
            data_d = 8'h0A;
         end
         LF: if (hs) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d = 1'b0;
            cnt_d = cnt_q + CNT_W'(1);
         end
`endif
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_tx_msg_seq.sv
// tb_tx_msg_seq: table-driven stall patterns with a byte scoreboard for tx_msg_seq
module tb_tx_msg_seq;
`ifdef TX_MSG_CRLF_EN
   localparam int MLEN = 12;
`else
   localparam int MLEN = 10;
`endif
   localparam int DEB = 16;
   logic       SYS_CLK = 1'b0, SYS_RST = 1'b1, BTN = 1'b0, TX_READY = 1'b0;
   logic [7:0] TX_DATA;
   logic       TX_VALID, BUSY;
   logic [1:0] MSG_COUNT;
   int total = 0, bad = 0;
   logic [7:0] q [$];
   typedef struct {int stall; logic [7:0] data;} vec_t;
   vec_t tab [MLEN];

   tx_msg_seq #(.DEBOUNCE_CYCLES(DEB), .CNT_W(2)) dut (
      .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .BTN(BTN), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
      .TX_READY(TX_READY), .BUSY(BUSY), .MSG_COUNT(MSG_COUNT));

   always #5 SYS_CLK = ~SYS_CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge SYS_CLK);
      #1;
   endtask

   // scoreboard and hold-stability monitor, sampled away from the active edge
   logic pv = 1'b0;
   logic [7:0] pd = 8'h00;
   always @(negedge SYS_CLK) begin
      if (SYS_RST) pv = 1'b0;
      else begin
         if (pv) begin
            chk("hold_valid", 32'(TX_VALID), 1);
            chk("hold_data", 32'(TX_DATA), 32'(pd));
         end
         if (TX_VALID && TX_READY) begin
            if (q.size() == 0) chk("sb_unexpected_byte", 32'(TX_DATA), 32'h100);
            else chk("sb_byte", 32'(TX_DATA), 32'(q.pop_front()));
         end
         pv = TX_VALID && !TX_READY;
         pd = TX_DATA;
      end
   end

   task automatic wait_valid(input string name);
      int k = 0;
      do begin
         step();
         k++;
      end while (!TX_VALID && k < 100);
      chk(name, k, DEB + 3);
      for (int i = 0; i < MLEN; i++) q.push_back(tab[i].data);
   endtask

   task automatic press();
      BTN = 1'b0;
      repeat (25) step();
      BTN = 1'b1;
      wait_valid("latency");
   endtask

   task automatic send_msg(input bit stall_on, input int n);
      logic hs;
      for (int i = 0; i < n; i++) begin
         if (stall_on && tab[i].stall > 0) begin
            TX_READY = 1'b0;
            repeat (tab[i].stall) step();
         end
         TX_READY = 1'b1;
         hs = 1'b0;
         for (int k = 0; k < 50 && !hs; k++) begin
            hs = TX_VALID;
            step();
         end
         chk("hs_timeout", 32'(hs), 1);
      end
   endtask

   task automatic end_checks(input logic [1:0] cnt);
      chk("end_valid", 32'(TX_VALID), 0);
      chk("end_busy", 32'(BUSY), 0);
      chk("end_count", 32'(MSG_COUNT), 32'(cnt));
      chk("sb_empty", q.size(), 0);
   endtask

   initial begin
      logic saw;
      tab[0] = '{4, 8'h48}; tab[1] = '{3, 8'h45}; tab[2] = '{5, 8'h4C}; tab[3] = '{4, 8'h4C};
      tab[4] = '{3, 8'h4F}; tab[5] = '{4, 8'h20}; tab[6] = '{5, 8'h54}; tab[7] = '{3, 8'h41};
      tab[8] = '{4, 8'h4E}; tab[9] = '{4, 8'h47};
`ifdef TX_MSG_CRLF_EN
      tab[10] = '{3, 8'h0D}; tab[11] = '{4, 8'h0A};
`endif
      repeat (3) step();
      chk("rst_valid", 32'(TX_VALID), 0);
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_count", 32'(MSG_COUNT), 0);
      chk("rst_data", 32'(TX_DATA), 0);
      SYS_RST = 1'b0;
      TX_READY = 1'b1;
      press();
      chk("busy_in_msg", 32'(BUSY), 1);
      send_msg(1'b0, MLEN);
      end_checks(2'd1);
      BTN = 1'b0;
      repeat (25) step();
      BTN = 1'b1;
      repeat (5) step();
      BTN = 1'b0;
      saw = 1'b0;
      repeat (40) begin
         step();
         saw |= TX_VALID;
      end
      chk("glitch_no_valid", 32'(saw), 0);
      chk("glitch_count", 32'(MSG_COUNT), 1);
      press();
      fork
         send_msg(1'b1, MLEN);
         begin
            BTN = 1'b0;
            repeat (20) step();
            BTN = 1'b1;
         end
      join
      end_checks(2'd2);
      saw = 1'b0;
      repeat (30) begin
         step();
         saw |= TX_VALID;
      end
      chk("no_requeue", 32'(saw), 0);
      for (int m = 0; m < 3; m++) begin
         press();
         send_msg(1'b0, MLEN);
         end_checks(2'(m + 3));
      end
      press();
      send_msg(1'b0, 5);
      SYS_RST = 1'b1;
      step();
      SYS_RST = 1'b0;
      q.delete();
      chk("midrst_valid", 32'(TX_VALID), 0);
      chk("midrst_busy", 32'(BUSY), 0);
      chk("midrst_count", 32'(MSG_COUNT), 0);
      wait_valid("rst_relatency");
      chk("restart_byte0", 32'(TX_DATA), 32'h48);
      send_msg(1'b0, MLEN);
      end_checks(2'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
